mul_sequencer: RTL

- Multi-cycle shift-and-add multiplier controller for the CPU's non-Mano MUL instruction (opcode 0000011, function code FMUL).
- The control unit pulses start during execute, stalls while busy is high, and captures the result and flags on done.
- Replaces a single-cycle combinational multiplier in the function unit so that CLK_PERIOD timing closes.
- Operates on one W-bit operand pair at a time. Returns the low W bits of the product together with Z, N and V flags.

---
 rtl/mul_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Multi-cycle shift-and-add multiplier for the MUL instruction. Operands are
//   converted to magnitudes at start. The magnitudes are multiplied one
//   multiplier bit per cycle. The 2W-bit product is then sign-corrected, and
//   the low W bits are returned together with Z/N/V flags.
//
//   Handshake: the requester pulses start while busy is low. start is taken
//   only in IDLE; a start seen in RUN or DONE is dropped, not queued. done is
//   a one-cycle pulse. result/z/n/v are valid from that cycle and hold until
//   the next done or reset.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     multiply request (sampled in IDLE only)
//   sgn       1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b      multiplicand / multiplier (sampled with start)
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle completion pulse
//   result    low DATA_WIDTH bits of the product
//   z, n, v   zero, negative (result MSB) and overflow flags
//   dbg_state current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module mul_sequencer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sgn,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z,
    output logic                  n,
    output logic                  v,
    output logic [1:0]            dbg_state
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [CW-1:0]  LAST_STEP = CW'(W);
    localparam logic [CW-1:0]  ONE_CNT   = CW'(1);
    localparam logic [W-1:0]   ONE_W     = W'(1);
    localparam logic [2*W-1:0] ONE_2W    = (2 * W)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplr_q, mplr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q, neg_d;
    logic            sgn_q, sgn_d;
    logic [W-1:0]    result_q, result_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            v_q, v_d;

    // Datapath intermediates
    logic [W:0]      add_term;
    logic [W:0]      sum;
    logic [2*W-1:0]  prod;
    logic [W:0]      prod_top;

    // ------------------------------------------------------------------
    // State register and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
            sgn_q    <= sgn_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // RUN spends W cycles on add/shift steps (count 0..W-1). It then spends
    // one more cycle (count == W) on the sign correction. This keeps the
    // 2W-bit negate off the adder path. Start to done is W+2 cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (count_q == LAST_STEP) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
        result    = result_q;
        z         = z_q;
        n         = n_q;
        v         = v_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        count_d  = count_q;
        neg_d    = neg_q;
        sgn_d    = sgn_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;

        // The (W+1)-bit adder keeps the carry out of the upper half. The
        // following right shift brings that carry back into the accumulator.
        add_term = mplr_q[0] ? {1'b0, mcand_q} : '0;
        sum      = {1'b0, acc_q[2*W-1:W]} + add_term;

        prod     = neg_q ? (~acc_q + ONE_2W) : acc_q;
        // In signed mode the product fits if bits 2W-1..W-1 are all equal.
        prod_top = prod[2*W-1:W-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // -2^(W-1) negates to itself, which is its correct
                    // unsigned magnitude.
                    mcand_d = (sgn && a[W-1]) ? (~a + ONE_W) : a;
                    mplr_d  = (sgn && b[W-1]) ? (~b + ONE_W) : b;
                    neg_d   = sgn & (a[W-1] ^ b[W-1]);
                    sgn_d   = sgn;
                    acc_d   = '0;
                    count_d = '0;
                end
            end
            S_RUN: begin
                if (count_q != LAST_STEP) begin
                    acc_d   = {sum, acc_q[W-1:1]};
                    mplr_d  = {1'b0, mplr_q[W-1:1]};
                    count_d = count_q + ONE_CNT;
                end else begin
                    result_d = prod[W-1:0];
                    z_d      = (prod[W-1:0] == '0);
                    n_d      = prod[W-1];
                    if (sgn_q) begin
                        v_d = !((prod_top == '0) || (prod_top == '1));
                    end else begin
                        v_d = |prod[2*W-1:W];
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
